// File: rtl/ex_stage.sv
// ex_stage: registered ALU/branch-compare execute stage with a two-entry main/skid output buffer; optional clock-enable output under EX_STAGE_CLKGATE_EN
module ex_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      in_alu_ctrl,
  input  logic [XLEN-1:0] in_op_a,
  input  logic [XLEN-1:0] in_op_b,
  input  logic            in_is_branch,
  input  logic [2:0]      in_funct3,
  input  logic [4:0]      in_rd,
`ifdef EX_STAGE_CLKGATE_EN
  output logic            ex_clk_en,
`endif
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            out_zero,
  output logic            out_branch_taken,
  output logic [4:0]      out_rd
);
  typedef struct packed {
    logic [XLEN-1:0] res;
    logic            zero;
    logic            taken;
    logic [4:0]      rd;
  } entry_t;
  entry_t main_q, skid_q, new_e;
  logic main_v, skid_v, acc, xfer, en, slt, sltu;
  assign acc  = in_valid & in_ready;
  assign xfer = main_v & out_ready;
  assign slt  = $signed(in_op_a) < $signed(in_op_b);
  assign sltu = in_op_a < in_op_b;
`ifdef EX_STAGE_CLKGATE_EN
  assign ex_clk_en = rst_n & (acc | main_v | flush);
  assign en = ex_clk_en;
`else
  assign en = 1'b1;
`endif
  // ALU result plus zero flag and BEQ/BNE resolution for the incoming operation
  always_comb begin
    new_e = '0;
    new_e.res = in_alu_ctrl == 4'd1 ? in_op_a - in_op_b :
                in_alu_ctrl == 4'd2 ? in_op_a & in_op_b :
                in_alu_ctrl == 4'd3 ? in_op_a | in_op_b :
                in_alu_ctrl == 4'd4 ? in_op_a ^ in_op_b :
                in_alu_ctrl == 4'd5 ? {{(XLEN-1){1'b0}}, slt} :
                in_alu_ctrl == 4'd6 ? {{(XLEN-1){1'b0}}, sltu} :
                in_op_a + in_op_b;
    new_e.zero = new_e.res == '0;
    new_e.taken = in_is_branch & ((in_funct3 == 3'b000 & new_e.zero) | (in_funct3 == 3'b001 & ~new_e.zero));
    new_e.rd = in_rd;
  end
  // occupancy: skid refills main on transfer, accept fills main if free/leaving else skid
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
    end else begin
      main_v <= skid_v | acc | (main_v & ~xfer);
      skid_v <= (skid_v & ~xfer) | (acc & main_v & ~xfer);
    end
  end
  // entry data; skid has priority into main so FIFO order holds
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_q <= '0;
      skid_q <= '0;
    end else if (en && !flush) begin
      if (skid_v && xfer) main_q <= skid_q;
      else if (acc && (!main_v || xfer)) main_q <= new_e;
      if (acc && main_v && !xfer) skid_q <= new_e;
    end
  end
  assign in_ready         = ~skid_v;
  assign out_valid        = main_v;
  assign out_result       = main_q.res;
  assign out_zero         = main_q.zero;
  assign out_branch_taken = main_q.taken;
  assign out_rd           = main_q.rd;
endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 Parameter XLEN, default 32, datapath width in bits.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  synchronous reset, active low.
REQ-004 flush  input  1  discard all buffered results (pipeline redirect).
REQ-005 in_valid  input  1  upstream decode presents an operation.
REQ-006 in_ready  output  1  stage can accept an operation this cycle.
REQ-007 in_alu_ctrl  input  4  0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLT, 0110 SLTU.
REQ-008 in_op_a, in_op_b  input  XLEN each  source operands.
REQ-009 in_is_branch  input  1  operation is a conditional branch compare.
REQ-010 in_funct3  input  3  branch condition: 000 BEQ, 001 BNE.
REQ-011 in_rd  input  5  destination register tag, passed through.
REQ-012 out_valid  output  1  result entry available downstream.
REQ-013 out_ready  input  1  downstream accepts the entry this cycle.
REQ-014 out_result  output  XLEN  ALU result.
REQ-015 out_zero  output  1  out_result equals zero.
REQ-016 out_branch_taken  output  1  branch condition resolved true.
REQ-017 out_rd  output  5  destination tag of the presented entry.

Function
REQ-018 Accept occurs when in_valid and in_ready are both 1 on a rising edge; transfer occurs when out_valid and out_ready are both 1.
REQ-019 Result is computed from the accepted inputs and registered; latency from accept to out_valid is exactly 1 cycle when the buffer is empty.
REQ-020 ADD/SUB wrap modulo 2^XLEN; AND/OR/XOR are bitwise; SLT (signed) and SLTU (unsigned) produce 1 or 0, zero-extended to XLEN.
REQ-021 Codes 0111-1111 behave as ADD.
REQ-022 out_branch_taken is 1 only for in_is_branch=1 with funct3 000 and zero result, or funct3 001 and non-zero result; all other combinations give 0.
REQ-023 Storage is two entries, main and skid; outputs always present the main entry; order is strictly FIFO.
REQ-024 in_ready is a registered signal, equal to 1 when the skid entry is empty.
REQ-025 Accept while main is full and not transferring writes the skid entry; in_ready drops on the next cycle.
REQ-026 When main transfers and skid is full, skid moves to main in the same edge and in_ready returns to 1 on the next cycle.
REQ-027 Simultaneous accept and transfer with only main full replaces main with the new entry; no bubble.
REQ-028 No accept occurs while in_ready=0; no entry is lost or duplicated under any out_ready pattern.
REQ-029 flush=1 empties both entries on that edge; out_valid=0 and in_ready=1 on the next cycle; flush overrides a simultaneous accept, which is discarded.
REQ-030 Output data fields hold their value while out_valid=1 and out_ready=0.

Reset
REQ-031 While rst_n=0 at a rising edge: both entries empty, out_valid=0, in_ready=1, out_result=0, out_zero=0, out_branch_taken=0, out_rd=0.
REQ-032 Reset asserted mid-operation discards all buffered entries without producing a transfer; reset takes priority over flush.

Configuration
REQ-033 Macro EX_STAGE_CLKGATE_EN: when defined, adds output ex_clk_en (1 bit), equal to (in_valid and in_ready) or out_valid or flush, reset value 0; entry registers load only when ex_clk_en=1.
REQ-034 When EX_STAGE_CLKGATE_EN is undefined, port ex_clk_en is absent and registers load every cycle; observable handshake and data behaviour are identical in both builds.

Verification
REQ-035 ADD 0x7FFFFFFF+0x00000001, out_ready=1 -> out_result 0x80000000 one cycle later, out_zero=0.
REQ-036 SLT a=0xFFFFFFFF, b=0x00000001 -> 1; SLTU same operands -> 0.
REQ-037 Branch SUB a=b=5, funct3 000 -> out_zero=1, out_branch_taken=1; funct3 001 -> out_branch_taken=0.
REQ-038 out_ready=0, three back-to-back in_valid ops (rd 1,2,3) -> only rd 1,2 accepted, in_ready=0; out_ready=1 -> rd 1,2 delivered in order, then rd 3 accepted.
REQ-039 flush with both entries full and in_valid=1 -> next cycle out_valid=0, in_ready=1, no flushed rd ever appears on output.
REQ-040 rst_n=0 for one cycle while main is full -> out_valid=0, in_ready=1, all outputs zero next cycle.
